// File: rtl/i2s_decoder_pkg.sv
// Shared audio definitions for the I2S receive path: channel encoding,
// default sample width and the decoder FSM state encoding.
package i2s_decoder_pkg;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    localparam int DEFAULT_SAMPLE_BITS = 16;

    // Bits without a word-select change before the stream is considered stalled.
    localparam int STALL_BITS = 64;

    typedef enum logic {
        WAIT_SYNC  = 1'b0,
        SHIFT_WORD = 1'b1
    } state_t;

endpackage

// File: rtl/i2s_decoder_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input, with a rising-edge
// detector on the synchronised level (one extra flop of history).
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_o = chain[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev;

endmodule

// File: rtl/i2s_decoder.sv
// Philips I2S receiver: oversamples BCLK/LRCK/SDATA in the clk domain and
// delivers left/right samples as a pair with a one-clk valid strobe.
module i2s_decoder
    import i2s_decoder_pkg::*;
#(
    parameter int SAMPLE_BITS = DEFAULT_SAMPLE_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bclk_i,
    input  logic                   lrclk_i,
    input  logic                   dacdat_i,
    input  logic                   enable_i,
    output logic [SAMPLE_BITS-1:0] l_chan_o,
    output logic [SAMPLE_BITS-1:0] r_chan_o,
    output logic                   sample_valid_o,
    output logic                   frame_err_o,
    output logic                   locked_o
);

    localparam int CW = $clog2(SAMPLE_BITS + 2);
    localparam int RW = $clog2(STALL_BITS);

    logic bclk_level_unused, lrclk_rise_unused, dacdat_rise_unused;
    logic bclk_rise, lr_s, dat_s;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk(clk), .reset(reset), .din(bclk_i), .sync_o(bclk_level_unused), .rise_o(bclk_rise));
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk_sync (
        .clk(clk), .reset(reset), .din(lrclk_i), .sync_o(lr_s), .rise_o(lrclk_rise_unused));
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_dacdat_sync (
        .clk(clk), .reset(reset), .din(dacdat_i), .sync_o(dat_s), .rise_o(dacdat_rise_unused));

    state_t                 state, state_nxt;
    logic [SAMPLE_BITS-1:0] shift_reg, shift_nxt, l_hold, l_hold_nxt;
    logic [SAMPLE_BITS-1:0] l_out_nxt, r_out_nxt, shifted, word;
    logic [CW-1:0]          bit_cnt, bit_cnt_nxt, word_len, pad;
    logic [RW-1:0]          run_cnt, run_cnt_nxt;
    logic                   lrck_last, lr_primed, word_edge, bit_in_word, short_word;
    logic                   valid_nxt, err_nxt, locked_nxt;

    // lrck_last only becomes meaningful after one sampled bit, so the first
    // bclk rise after reset primes it instead of faking a word edge.
    assign word_edge   = bclk_rise & lr_primed & (lr_s != lrck_last);
    assign bit_in_word = bit_cnt < CW'(SAMPLE_BITS);
    assign shifted     = bit_in_word ? {shift_reg[SAMPLE_BITS-2:0], dat_s} : shift_reg;
    assign word_len    = bit_in_word ? bit_cnt + 1'b1 : bit_cnt;
    assign short_word  = word_len < CW'(SAMPLE_BITS);
    assign pad         = short_word ? CW'(SAMPLE_BITS) - word_len : '0;
    assign word        = shifted << pad;

    // sample_valid_o is a strobe, not a handshake: l_chan_o/r_chan_o change
    // only in the cycle it is high and hold until the next strobe.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        run_cnt_nxt = run_cnt;
        l_hold_nxt  = l_hold;
        l_out_nxt   = l_chan_o;
        r_out_nxt   = r_chan_o;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        locked_nxt  = locked_o;
        if (!enable_i) begin
            state_nxt   = WAIT_SYNC;
            locked_nxt  = 1'b0;
            shift_nxt   = '0;
            bit_cnt_nxt = '0;
            run_cnt_nxt = '0;
        end else begin
            case (state)
                WAIT_SYNC: begin
                    if (word_edge) begin
                        state_nxt   = SHIFT_WORD;
                        shift_nxt   = '0;
                        bit_cnt_nxt = '0;
                        run_cnt_nxt = '0;
                        l_hold_nxt  = '0;
                    end
                end
                SHIFT_WORD: begin
                    if (word_edge) begin
                        shift_nxt   = '0;
                        bit_cnt_nxt = '0;
                        run_cnt_nxt = '0;
                        err_nxt     = short_word;
                        if (lrck_last == LEFT) begin
                            l_hold_nxt = word;
                        end else begin
                            l_out_nxt  = l_hold;
                            r_out_nxt  = word;
                            valid_nxt  = 1'b1;
                            locked_nxt = 1'b1;
                        end
                    end else if (bclk_rise) begin
                        shift_nxt = shifted;
                        if (bit_cnt != CW'(SAMPLE_BITS + 1))
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        if (run_cnt == RW'(STALL_BITS - 1)) begin
                            state_nxt   = WAIT_SYNC;
                            locked_nxt  = 1'b0;
                            shift_nxt   = '0;
                            bit_cnt_nxt = '0;
                            run_cnt_nxt = '0;
                        end else begin
                            run_cnt_nxt = run_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = WAIT_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= WAIT_SYNC;
            shift_reg      <= '0;
            bit_cnt        <= '0;
            run_cnt        <= '0;
            l_hold         <= '0;
            lrck_last      <= 1'b0;
            lr_primed      <= 1'b0;
            l_chan_o       <= '0;
            r_chan_o       <= '0;
            sample_valid_o <= 1'b0;
            frame_err_o    <= 1'b0;
            locked_o       <= 1'b0;
        end else begin
            state          <= state_nxt;
            shift_reg      <= shift_nxt;
            bit_cnt        <= bit_cnt_nxt;
            run_cnt        <= run_cnt_nxt;
            l_hold         <= l_hold_nxt;
            l_chan_o       <= l_out_nxt;
            r_chan_o       <= r_out_nxt;
            sample_valid_o <= valid_nxt;
            frame_err_o    <= err_nxt;
            locked_o       <= locked_nxt;
            if (bclk_rise) begin
                lrck_last <= lr_s;
                lr_primed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_decoder.sv
// Directed bench for i2s_decoder: drives I2S frames of several word lengths,
// a stall, an orphan right word, a mid-word reset and a disable.
module tb_i2s_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bclk = 1'b1;
    logic        lrclk = 1'b1;
    logic        dacdat = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] l_chan, r_chan;
    logic        sample_valid, frame_err, locked;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int valid_seen = 0;
    int bclk_half = 15;
    logic valid_prev = 1'b0;
    logic [31:0] exp_q[$];

    i2s_decoder dut (
        .clk(clk), .reset(reset), .bclk_i(bclk), .lrclk_i(lrclk), .dacdat_i(dacdat),
        .enable_i(enable), .l_chan_o(l_chan), .r_chan_o(r_chan),
        .sample_valid_o(sample_valid), .frame_err_o(frame_err), .locked_o(locked)
    );

    // clock / reset
    always #10 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not complete (got stuck, required finish)");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks: data and word select change on the bclk falling edge
    task automatic bit_cycle(input logic lr, input logic d);
        bclk = 1'b0;
        lrclk = lr;
        dacdat = d;
        repeat (bclk_half) @(negedge clk);
        bclk = 1'b1;
        repeat (bclk_half) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits, input logic ch);
        for (int i = nbits - 1; i >= 0; i--)
            bit_cycle((i == 0) ? ~ch : ch, w[i]);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits,
                              input logic [15:0] exp_l, input logic [15:0] exp_r);
        exp_q.push_back({exp_l, exp_r});
        send_word(l, nbits, 1'b0);
        send_word(r, nbits, 1'b1);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            if (frame_err) err_seen++;
            if (sample_valid) begin
                valid_seen++;
                if (valid_prev) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_width: got 2-cycle pulse expected 1-cycle pulse");
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got l=%0h r=%0h expected no output", l_chan, r_chan);
                end else begin
                    e = exp_q.pop_front();
                    check("l_chan", {16'h0, l_chan}, {16'h0, e[31:16]});
                    check("r_chan", {16'h0, r_chan}, {16'h0, e[15:0]});
                end
            end
            valid_prev = sample_valid;
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_l", {16'h0, l_chan}, 32'h0);
        check("rst_r", {16'h0, r_chan}, 32'h0);
        check("rst_valid", {31'h0, sample_valid}, 32'h0);
        check("rst_err", {31'h0, frame_err}, 32'h0);
        check("rst_locked", {31'h0, locked}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // stream begins mid right word; the sync edge enters a left word
        for (int i = 0; i < 3; i++) bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b0, 1'b0);
        check("unlocked_before_frame", {31'h0, locked}, 32'h0);
        for (int i = 0; i < 3; i++) send_frame(32'h8001, 32'h7FFE, 16, 16'h8001, 16'h7FFE);
        repeat (4) @(negedge clk);
        check("loopback_valid_count", valid_seen, 3);
        check("loopback_err_count", err_seen, 0);
        check("locked_after_frame", {31'h0, locked}, 32'h1);

        bclk_half = 6;
        for (int i = 0; i < 2; i++) send_frame(32'h123456, 32'hFEDCBA, 24, 16'h1234, 16'hFEDC);
        repeat (4) @(negedge clk);
        check("w24_err_count", err_seen, 0);

        for (int i = 0; i < 2; i++) send_frame(32'hABC, 32'h123, 12, 16'hABC0, 16'h1230);
        repeat (4) @(negedge clk);
        check("w12_err_count", err_seen, 4);
        check("locked_before_stall", {31'h0, locked}, 32'h1);

        // stalled word select
        for (int i = 0; i < 70; i++) bit_cycle(1'b0, 1'b1);
        check("unlocked_after_stall", {31'h0, locked}, 32'h0);
        check("stall_valid_count", valid_seen, 7);

        // relock through an orphan right word, then a normal frame
        bit_cycle(1'b1, 1'b0);
        exp_q.push_back({16'h0000, 16'h5A5A});
        send_word(32'h5A5A, 16, 1'b1);
        repeat (4) @(negedge clk);
        check("locked_after_orphan", {31'h0, locked}, 32'h1);
        send_frame(32'h1111, 32'h2222, 16, 16'h1111, 16'h2222);
        repeat (4) @(negedge clk);

        // reset in the middle of a right word
        send_word(32'h3333, 16, 1'b0);
        for (int i = 0; i < 8; i++) bit_cycle(1'b1, 1'b1);
        check("pre_reset_l", {16'h0, l_chan}, 32'h1111);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_l", {16'h0, l_chan}, 32'h0);
        check("mid_rst_r", {16'h0, r_chan}, 32'h0);
        check("mid_rst_locked", {31'h0, locked}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b0, 1'b1);
        check("post_rst_valid_count", valid_seen, 9);
        check("post_rst_locked", {31'h0, locked}, 32'h0);
        send_frame(32'h0F0F, 32'hF0F0, 16, 16'h0F0F, 16'hF0F0);
        repeat (4) @(negedge clk);
        check("relock_after_rst", {31'h0, locked}, 32'h1);

        // disable drops lock but holds the samples
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("disable_locked", {31'h0, locked}, 32'h0);
        check("disable_hold_l", {16'h0, l_chan}, 32'h0F0F);
        check("disable_hold_r", {16'h0, r_chan}, 32'hF0F0);

        check("final_valid_count", valid_seen, 10);
        check("final_err_count", err_seen, 4);
        check("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
